cell_array_seq: RTL
===================

Name: cell_array_seq

Overview:
- Command sequencer that drives the row-parallel cell array from its control side.
- Accepts one register-level command at a time over a valid/ready handshake.
- Converts binary row indices into the array's one-hot read/write selects, write enables, op_fa and carry_in.
- Waits the array's settle latency, then captures read data or the overflow flag and returns a response to the core.

Parameters:
- COLS, 32, data width per row.
- ROWS, 32, number of array rows.
- AW, $clog2(ROWS), width of binary row index.
- LAT, 1, cycles from select assertion to valid array outputs (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0 ADD, 1 AND, 2 XOR, 3 OR, 4 LOAD, 5 READ, 6 ADDC, 7 illegal.
- cmd_dst  in  AW  destination row.
- cmd_src_a  in  AW  up-bus source row.
- cmd_src_b  in  AW  down-bus source row.
- cmd_data  in  COLS  LOAD data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  COLS  READ data, else 0.
- rsp_ovf  out  1  overflow[dst] of an arithmetic op.
- rsp_err  out  1  command rejected.
- arr_rd_addr_up  out  ROWS  one-hot up read select.
- arr_rd_addr_dn  out  ROWS  one-hot down read select.
- arr_wr_addr_up  out  ROWS  one-hot up write select.
- arr_wr_addr_dn  out  ROWS  one-hot down write select (always 0).
- arr_wr_en  out  ROWS  one-hot row write enable.
- arr_op_fa  out  4  fa op enable (ADD/ADDC 0001, AND 0010, XOR 0100, OR 1000).
- arr_carry_in  out  1  1 only for ADDC.
- arr_data_in_up  out  COLS  LOAD data to array.
- arr_data_in_dn  out  COLS  always 0.
- arr_rd_out_up  in  COLS  array up read output.
- arr_overflow  in  ROWS  per-row overflow.

Behaviour:
- Reset (rst low, async): state IDLE; cmd_ready=1; every other output 0.
- All outputs are registered; array controls are held stable for the whole of each state.
- States: IDLE, ISSUE, WAIT, WB, RESP.

IDLE:
- cmd_ready=1; command accepted when cmd_valid&cmd_ready; fields latched.
- Illegal command: op 7, any index >= ROWS, or a LOAD/ALU op with dst=0 (row 0 is read-only). Goes to RESP with rsp_err=1; no array signal toggles.
- READ and ALU ops go to ISSUE; LOAD goes to WB.

ISSUE (1 cycle):
- arr_rd_addr_up=1<<src_a; for ALU ops also arr_rd_addr_dn=1<<src_b, plus op_fa and carry_in.
- Next state WAIT; wait counter loaded with LAT-1.

WAIT:
- Holds the ISSUE outputs; counts down; on 0 captures arr_rd_out_up (READ) or arr_overflow[dst] (ALU).
- READ goes to RESP; ALU goes to WB.

WB (1 cycle):
- arr_wr_en=arr_wr_addr_up=1<<dst.
- ALU ops keep read selects and op_fa held; LOAD drives arr_data_in_up=cmd_data.
- Next state RESP.

RESP:
- rsp_valid=1; all array selects/enables 0; rsp fields stable until rsp_ready.
- Then IDLE; cmd_ready reasserts the cycle after the handshake.

Latency: ALU 3+LAT cycles accept-to-rsp_valid, READ 2+LAT, LOAD 2, error 1.

Rules:
- One-hot vectors never have more than one bit set.
- src_a=src_b is legal.
- dst equal to a source is legal, since the write happens after capture.
- cmd_valid while busy is ignored; cmd_ready=0 outside IDLE.
- rsp_ready held high gives back-to-back throughput.
- Reset mid-command aborts immediately; no write is issued after reset release.

Test Plan:
- Reset then LOAD dst=3 data=0xDEADBEEF -> one WB cycle with arr_wr_en=0x8 and arr_data_in_up=0xDEADBEEF; rsp_valid at cycle 2; rsp_err=0.
- READ src_a=3, LAT=2, array returns 0xDEADBEEF -> arr_rd_addr_up=0x8 held 3 cycles; rsp_data=0xDEADBEEF at cycle 4.
- ADDC dst=5 a=3 b=4 -> ISSUE shows rd_up=0x8, rd_dn=0x10, op_fa=0001, carry_in=1; WB shows wr_en=0x20; rsp_ovf equals arr_overflow[5].
- LOAD dst=0, op=7, and src_a=40 with ROWS=32 -> each gives rsp_err=1 one cycle after accept; arr_wr_en stays 0.
- XOR with rsp_ready low for 5 cycles -> rsp fields stable, cmd_ready=0, a second cmd_valid is not accepted until the handshake.
- Assert rst during WAIT of an ADD -> all outputs 0 asynchronously; no arr_wr_en pulse after release; cmd_ready=1.

Source files
------------

// File: rtl/cell_array_seq_if.sv
// Command/response interface between the core and the cell array sequencer.
//   cmd_*  : one register-level command per valid/ready handshake (core -> sequencer)
//   rsp_*  : one response per command (sequencer -> core)
// master : core side      slave : sequencer side
`timescale 1ns/1ps
interface cell_array_seq_if #(
  parameter int COLS = 32,
  parameter int AW   = 5
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [AW-1:0]   cmd_dst;
  logic [AW-1:0]   cmd_src_a;
  logic [AW-1:0]   cmd_src_b;
  logic [COLS-1:0] cmd_data;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [COLS-1:0] rsp_data;
  logic            rsp_ovf;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/cell_array_seq.sv
// Command sequencer driving the row-parallel cell array from its control side.
// Takes one command at a time, turns binary row indices into one-hot selects,
// waits the array settle latency, captures read data / overflow and responds.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   bus (slave)       : cmd_* command handshake, rsp_* response handshake
//   arr_rd_addr_up/dn : one-hot read selects (up / down bus)
//   arr_wr_addr_up/dn : one-hot write selects (down is always 0)
//   arr_wr_en         : one-hot row write enable
//   arr_op_fa         : function select (ADD/ADDC, AND, XOR, OR)
//   arr_carry_in      : carry into the adder, ADDC only
//   arr_data_in_up/dn : LOAD data (down is always 0)
//   arr_rd_out_up     : array read data
//   arr_overflow      : per-row overflow flags
`timescale 1ns/1ps
module cell_array_seq #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int AW   = $clog2(ROWS),
  parameter int LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  cell_array_seq_if.slave bus,
  output logic [ROWS-1:0] arr_rd_addr_up,
  output logic [ROWS-1:0] arr_rd_addr_dn,
  output logic [ROWS-1:0] arr_wr_addr_up,
  output logic [ROWS-1:0] arr_wr_addr_dn,
  output logic [ROWS-1:0] arr_wr_en,
  output logic [3:0]      arr_op_fa,
  output logic            arr_carry_in,
  output logic [COLS-1:0] arr_data_in_up,
  output logic [COLS-1:0] arr_data_in_dn,
  input  logic [COLS-1:0] arr_rd_out_up,
  input  logic [ROWS-1:0] arr_overflow
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_OR   = 3'd3,
    OP_LOAD = 3'd4,
    OP_READ = 3'd5,
    OP_ADDC = 3'd6,
    OP_ILL  = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB,
    RESP
  } state_t;

  // Bit i set when row index i exists; avoids a range compare that is
  // constant when ROWS is a power of two.
  localparam int NIDX = 2 ** AW;
  localparam logic [NIDX-1:0] ROW_OK = {NIDX{1'b1}} >> (NIDX - ROWS);

  state_t        state;
  op_t           op_q;
  logic [AW-1:0] dst_q;
  logic [2:0]    wait_cnt;
  op_t           cmd_op;
  logic          cmd_bad;

  function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] idx);
    return {{(ROWS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [3:0] fa_code(input op_t op);
    case (op)
      OP_AND:  return 4'b0010;
      OP_XOR:  return 4'b0100;
      OP_OR:   return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  always_comb begin
    cmd_op  = op_t'(bus.cmd_op);
    cmd_bad = 1'b0;
    if (cmd_op == OP_ILL)                      cmd_bad = 1'b1;
    if (!ROW_OK[bus.cmd_dst])                  cmd_bad = 1'b1;
    if (!ROW_OK[bus.cmd_src_a])                cmd_bad = 1'b1;
    if (!ROW_OK[bus.cmd_src_b])                cmd_bad = 1'b1;
    if (cmd_op != OP_READ && bus.cmd_dst == '0) cmd_bad = 1'b1;
  end

  // Down-bus write path and down-bus data are never used by this sequencer.
  assign arr_wr_addr_dn = '0;
  assign arr_data_in_dn = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      op_q           <= OP_ADD;
      dst_q          <= '0;
      wait_cnt       <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_ovf    <= 1'b0;
      bus.rsp_err    <= 1'b0;
      arr_rd_addr_up <= '0;
      arr_rd_addr_dn <= '0;
      arr_wr_addr_up <= '0;
      arr_wr_en      <= '0;
      arr_op_fa      <= '0;
      arr_carry_in   <= 1'b0;
      arr_data_in_up <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_err   <= 1'b0;
            op_q          <= cmd_op;
            dst_q         <= bus.cmd_dst;
            if (cmd_bad) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else if (cmd_op == OP_LOAD) begin
              // LOAD needs no read, so the write is issued straight away.
              state          <= WB;
              arr_wr_en      <= onehot(bus.cmd_dst);
              arr_wr_addr_up <= onehot(bus.cmd_dst);
              arr_data_in_up <= bus.cmd_data;
            end else begin
              state          <= ISSUE;
              arr_rd_addr_up <= onehot(bus.cmd_src_a);
              if (cmd_op != OP_READ) begin
                arr_rd_addr_dn <= onehot(bus.cmd_src_b);
                arr_op_fa      <= fa_code(cmd_op);
                arr_carry_in   <= (cmd_op == OP_ADDC);
              end
            end
          end
        end

        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= 3'(LAT - 1);
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            if (op_q == OP_READ) begin
              bus.rsp_data   <= arr_rd_out_up;
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              arr_rd_addr_up <= '0;
            end else begin
              // Selects and function stay up so the array keeps driving the
              // result while it is written back into dst.
              bus.rsp_ovf    <= arr_overflow[dst_q];
              state          <= WB;
              arr_wr_en      <= onehot(dst_q);
              arr_wr_addr_up <= onehot(dst_q);
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        WB: begin
          state          <= RESP;
          bus.rsp_valid  <= 1'b1;
          arr_rd_addr_up <= '0;
          arr_rd_addr_dn <= '0;
          arr_wr_addr_up <= '0;
          arr_wr_en      <= '0;
          arr_op_fa      <= '0;
          arr_carry_in   <= 1'b0;
          arr_data_in_up <= '0;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
